// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: groups the fetch unit's memory, redirect and decoder-side signals.
//  master: the fetch unit (drives imem request and the instruction stream)
//  slave : the surrounding system (instruction memory, branch unit, decoder)
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              imem_req_out;
  logic [ADDR_W-1:0] imem_addr_out;
  logic              imem_gnt_in;
  logic              imem_rvalid_in;
  logic [DATA_W-1:0] imem_rdata_in;
  logic              branch_valid_in;
  logic [ADDR_W-1:0] branch_target_in;
  logic              instr_valid_out;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc_out;
  logic              instr_ready_in;
  modport master (
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
    input  imem_gnt_in, imem_rvalid_in, imem_rdata_in, branch_valid_in, branch_target_in,
           instr_ready_in
  );
  modport slave (
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in, branch_valid_in, branch_target_in,
           instr_ready_in
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: decoupled fetch stage; credit-limited requests to a variable-latency
//  instruction memory, returned words buffered with their PC and handed downstream on valid/ready.
//  clk_in, rst_n_in : clock (rising edge), asynchronous active-low reset
//  bus (master)     : imem req/addr/gnt/rvalid/rdata, branch valid/target, instr valid/data/pc/ready
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  instr_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {START, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wr_ptr, rd_ptr, occ, outstanding, out_nx, drop_cnt, drop_nx;
  logic [ADDR_W-1:0] fetch_pc, ret_pc;
  logic [DATA_W+ADDR_W-1:0] mem [DEPTH];
  logic [DATA_W+ADDR_W-1:0] head;
  logic redirect, brk, fire, rv_ok, keep, push, pop, req, valid;
  assign occ     = wr_ptr - rd_ptr;
  assign valid   = occ != '0;
  assign brk     = bus.branch_valid_in && state != START;
  assign fire    = req && bus.imem_gnt_in;
  // a response with nothing outstanding is a protocol error and is ignored outright
  assign rv_ok   = bus.imem_rvalid_in && outstanding != '0;
  assign keep    = rv_ok && drop_cnt == '0;
  assign push    = keep && !brk;
  assign pop     = valid && bus.instr_ready_in;
  assign out_nx  = outstanding + CW'(fire) - CW'(rv_ok);
  assign drop_nx = drop_cnt - CW'(rv_ok && drop_cnt != '0);
  assign head    = mem[rd_ptr[PW-1:0]];
  assign bus.instr_valid_out = valid;
  assign bus.instr_out       = valid ? head[ADDR_W +: DATA_W] : '0;
  assign bus.instr_pc_out    = valid ? head[ADDR_W-1:0] : '0;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= START;
    else state <= state_nx;
  // everything still in flight after a branch is stale, so drain exactly that many responses
  always_comb
    state_nx = brk ? (out_nx != '0 ? DRAIN : FETCH) :
               state == START ? FETCH :
               (state == DRAIN && drop_nx == '0) ? FETCH : state;
  // buffered + in-flight words never exceed DEPTH, so a returning word always has a slot
  always_comb begin
    req = state == FETCH && !redirect && ({1'b0, occ} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    bus.imem_req_out  = req;
    bus.imem_addr_out = req ? fetch_pc : '0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      redirect    <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      redirect    <= brk;
      outstanding <= out_nx;
      drop_cnt    <= brk ? out_nx : drop_nx;
      fetch_pc    <= brk ? bus.branch_target_in : fire ? fetch_pc + ADDR_W'(1) : fetch_pc;
      ret_pc      <= brk ? bus.branch_target_in : push ? ret_pc + ADDR_W'(1) : ret_pc;
      wr_ptr      <= brk ? '0 : wr_ptr + CW'(push);
      rd_ptr      <= brk ? '0 : rd_ptr + CW'(pop);
    end
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr[PW-1:0]] <= {bus.imem_rdata_in, ret_pc};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit (reset, streaming, backpressure,
//  branch drain, simultaneous branch/gnt/rvalid/pop, PC wrap, async reset during drain).
module tb_instr_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(8'h00)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(b0));
  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(8'hFE)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(b1));
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gnt_cnt = 0;
  int gnt_lim = 0;
  int g1_cnt = 0;
  int base, rel;
  bit rv_en = 1'b1;
  bit found;
  bit g1_prev = 1'b0;
  logic [AW-1:0] g1_a;
  logic [AW-1:0] exp0[$];
  logic [AW-1:0] exp1[$];
  logic [AW-1:0] pend_a[$];
  int pend_e[$];
  int pops0[$];
  int pops1[$];
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // memory models: dut0 has grant budget and a holdable in-order response queue,
  // dut1 answers every grant one cycle later
  task automatic drive_mem();
    b0.imem_rvalid_in = 1'b0;
    b0.imem_rdata_in  = '0;
    if (rv_en && pend_a.size() > 0 && pend_e[0] <= cyc) begin
      b0.imem_rvalid_in = 1'b1;
      b0.imem_rdata_in  = word(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_e.pop_front());
    end
    b0.imem_gnt_in = gnt_cnt < gnt_lim;
    if (b0.imem_req_out && b0.imem_gnt_in) begin
      pend_a.push_back(b0.imem_addr_out);
      pend_e.push_back(cyc + 1);
      gnt_cnt++;
    end
    b1.imem_rvalid_in = g1_prev;
    b1.imem_rdata_in  = g1_prev ? word(g1_a) : '0;
    b1.imem_gnt_in    = g1_cnt < 4;
    g1_prev = b1.imem_req_out && b1.imem_gnt_in;
    if (g1_prev) begin
      g1_a = b1.imem_addr_out;
      g1_cnt++;
    end
  endtask
  task automatic monitor();
    logic [AW-1:0] e;
    if (b0.instr_valid_out && b0.instr_ready_in) begin
      pops0.push_back(cyc);
      if (exp0.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut0 spurious pop: got pc %0h, expected no delivery", b0.instr_pc_out);
      end else begin
        e = exp0.pop_front();
        check("dut0 pc", b0.instr_pc_out, e);
        check("dut0 instr", b0.instr_out, word(e));
      end
    end
    if (b1.instr_valid_out && b1.instr_ready_in) begin
      pops1.push_back(cyc);
      if (exp1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut1 spurious pop: got pc %0h, expected no delivery", b1.instr_pc_out);
      end else begin
        e = exp1.pop_front();
        check("dut1 pc", b1.instr_pc_out, e);
        check("dut1 instr", b1.instr_out, word(e));
      end
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, " req"}, b0.imem_req_out, 0);
    check({tag, " addr"}, b0.imem_addr_out, 0);
    check({tag, " valid"}, b0.instr_valid_out, 0);
    check({tag, " instr"}, b0.instr_out, 0);
    check({tag, " pc"}, b0.instr_pc_out, 0);
  endtask
  initial begin
    b0.imem_gnt_in = 1'b0; b0.imem_rvalid_in = 1'b0; b0.imem_rdata_in = '0;
    b0.branch_valid_in = 1'b0; b0.branch_target_in = '0; b0.instr_ready_in = 1'b0;
    b1.imem_gnt_in = 1'b0; b1.imem_rvalid_in = 1'b0; b1.imem_rdata_in = '0;
    b1.branch_valid_in = 1'b0; b1.branch_target_in = '0; b1.instr_ready_in = 1'b1;
    fork
      forever @(posedge clk) cyc++;
      forever begin @(negedge clk); drive_mem(); end
      forever begin @(negedge clk); monitor(); end
    join_none
    // T1: reset state, then four back-to-back words; dut1 (T5) wraps FE,FF,00,01
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset dut1 req", b1.imem_req_out, 0);
    b0.instr_ready_in = 1'b1;
    gnt_lim = 4;
    exp0 = '{8'h00, 8'h01, 8'h02, 8'h03};
    exp1 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    step(12);
    check("t1 drained", exp0.size(), 0);
    check("t1 pop count", pops0.size(), 4);
    if (pops0.size() == 4) begin
      check("t1 first pop latency", pops0[0] - rel, 3);
      check("t1 one per cycle", pops0[3] - pops0[0], 3);
    end
    check("t5 drained", exp1.size(), 0);
    check("t5 pop count", pops1.size(), 4);
    if (pops1.size() == 4) check("t5 no stall at wrap", pops1[3] - pops1[0], 3);
    // T2: backpressure stops requests at four credits; one pop frees exactly one
    b0.instr_ready_in = 1'b0;
    base = gnt_cnt;
    gnt_lim = gnt_cnt + 5;
    exp0 = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    step(10);
    check("t2 grants while blocked", gnt_cnt - base, 4);
    check("t2 req dropped", b0.imem_req_out, 0);
    check("t2 head valid", b0.instr_valid_out, 1);
    check("t2 head pc stable", b0.instr_pc_out, 8'h04);
    b0.instr_ready_in = 1'b1;
    step(1);
    b0.instr_ready_in = 1'b0;
    check("t2 req after pop", b0.imem_req_out, 1);
    check("t2 addr after pop", b0.imem_addr_out, 8'h08);
    step(6);
    check("t2 grants total", gnt_cnt - base, 5);
    b0.instr_ready_in = 1'b1;
    step(8);
    check("t2 drained", exp0.size(), 0);
    check("t2 req no gnt", b0.imem_req_out, 1);
    check("t2 addr held", b0.imem_addr_out, 8'h09);
    step(3);
    check("t2 addr still held", b0.imem_addr_out, 8'h09);
    // T3: branch with three requests in flight; their responses are dropped
    rv_en = 1'b0;
    base = gnt_cnt;
    gnt_lim = gnt_cnt + 3;
    step(6);
    check("t3 in flight", gnt_cnt - base, 3);
    b0.branch_valid_in = 1'b1;
    b0.branch_target_in = 8'h40;
    step(1);
    b0.branch_valid_in = 1'b0;
    check("t3 req low after branch", b0.imem_req_out, 0);
    step(3);
    check("t3 req low in drain", b0.imem_req_out, 0);
    check("t3 fifo empty", b0.instr_valid_out, 0);
    rv_en = 1'b1;
    gnt_lim = gnt_cnt + 2;
    exp0 = '{8'h40, 8'h41};
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (b0.imem_req_out) found = 1'b1;
      else step(1);
    end
    check("t3 req resumes", found, 1);
    check("t3 resume addr", b0.imem_addr_out, 8'h40);
    step(8);
    check("t3 drained", exp0.size(), 0);
    // T4: branch in the same cycle as gnt(0x44), rvalid(0x43) and pop(0x42)
    exp0 = '{8'h42};
    gnt_lim = gnt_cnt + 3;
    step(2);
    b0.branch_valid_in = 1'b1;
    b0.branch_target_in = 8'h80;
    step(1);
    b0.branch_valid_in = 1'b0;
    check("t4 popped head", exp0.size(), 0);
    check("t4 fifo empty", b0.instr_valid_out, 0);
    check("t4 req low", b0.imem_req_out, 0);
    exp0 = '{8'h80};
    gnt_lim = gnt_cnt + 1;
    step(8);
    check("t4 drained", exp0.size(), 0);
    // T6: async reset while draining, stale responses afterwards are ignored
    rv_en = 1'b0;
    base = gnt_cnt;
    gnt_lim = gnt_cnt + 2;
    step(5);
    check("t6 in flight", gnt_cnt - base, 2);
    b0.branch_valid_in = 1'b1;
    b0.branch_target_in = 8'h10;
    step(1);
    b0.branch_valid_in = 1'b0;
    check("t6 drain req low", b0.imem_req_out, 0);
    #1 rst_n = 1'b0;
    #1 check_zero("t6 async reset");
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    rv_en = 1'b1;
    step(6);
    check("t6 stale ignored", b0.instr_valid_out, 0);
    exp0 = '{8'h00};
    gnt_lim = gnt_cnt + 1;
    step(8);
    check("t6 fetch after reset", exp0.size(), 0);
    check("t6 dut1 quiet", exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
